multicycle_ctrl: RTL and testbench

//  Moore FSM that sequences the shared multi-cycle MIPS datapath: one ALU, one unified memory port, one register file.

---
 rtl/multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the shared multi-cycle MIPS datapath (IF/ID/EX/MEM/WB + TRAP).
// Optional performance counters are compiled in with `define MC_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int WAIT_MAX = 16
`ifdef MC_PERF_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       op_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic             se_o,
    output logic             shift_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic [2:0]       state_o,
    output logic             trap_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [CNT_W-1:0] ins_cnt_o
`endif
);

    // state | meaning
    // IF    | fetch via PC, PC <= PC+4 on ack
    // ID    | decode, branch target into ALUOut, j/jal resolve here
    // EX    | ALU op / address calc / branch compare / jr
    // MEM   | lw/sw data access via ALUOut
    // WB    | register file write
    // TRAP  | illegal opcode or memory timeout, held until reset
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                in_access;
    logic                timeout;

    assign in_access = (state == S_IF) || (state == S_MEM);
    assign timeout   = in_access && !mem_ack_i && (wait_cnt == WAIT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IF;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
        end else if (in_access && !mem_ack_i && !timeout) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Outputs are gated by rst_i so a request in flight drops the moment reset asserts.
    always_comb begin
        next_state   = state;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'd0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'd0;
        alu_op_o     = 3'b000;
        se_o         = 1'b0;
        shift_o      = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'd0;
        mem_to_reg_o = 2'd0;
        if (rst_i) begin
            case (state)
                S_IF: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = 2'd1;
                    if (timeout) begin
                        next_state = S_TRAP;
                    end else if (mem_ack_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        next_state = S_ID;
                    end
                end
                S_ID: begin
                    alu_src_b_o = 2'd3;
                    se_o        = 1'b1;
                    case (op_i)
                        OP_R, OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI,
                        OP_LW, OP_SW, OP_BEQ, OP_BNE: next_state = S_EX;
                        OP_J: begin
                            pc_write_o = 1'b1;
                            pc_src_o   = 2'd2;
                            next_state = S_IF;
                        end
                        OP_JAL: begin
                            pc_write_o   = 1'b1;
                            pc_src_o     = 2'd2;
                            reg_write_o  = 1'b1;
                            reg_dst_o    = 2'd2;
                            mem_to_reg_o = 2'd2;
                            next_state   = S_IF;
                        end
                        default: next_state = S_TRAP;
                    endcase
                end
                S_EX: begin
                    alu_src_a_o = 1'b1;
                    case (op_i)
                        OP_R: begin
                            alu_op_o = 3'b010;
                            shift_o  = (funct_i == FN_SRA);
                            if (funct_i == FN_JR) begin
                                pc_write_o = 1'b1;
                                pc_src_o   = 2'd3;
                                next_state = S_IF;
                            end else begin
                                next_state = S_WB;
                            end
                        end
                        OP_ADDI: begin
                            alu_src_b_o = 2'd2;
                            se_o        = 1'b1;
                            next_state  = S_WB;
                        end
                        OP_SLTIU: begin
                            alu_src_b_o = 2'd2;
                            alu_op_o    = 3'b110;
                            next_state  = S_WB;
                        end
                        OP_LUI: begin
                            alu_src_b_o = 2'd2;
                            alu_op_o    = 3'b011;
                            se_o        = 1'b1;
                            next_state  = S_WB;
                        end
                        OP_ORI: begin
                            alu_src_b_o = 2'd2;
                            alu_op_o    = 3'b100;
                            next_state  = S_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_src_b_o = 2'd2;
                            se_o        = 1'b1;
                            next_state  = S_MEM;
                        end
                        OP_BEQ: begin
                            alu_op_o   = 3'b001;
                            pc_write_o = zero_i;
                            pc_src_o   = 2'd1;
                            next_state = S_IF;
                        end
                        OP_BNE: begin
                            alu_op_o   = 3'b101;
                            pc_write_o = !zero_i;
                            pc_src_o   = 2'd1;
                            next_state = S_IF;
                        end
                        default: next_state = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                    mem_we_o  = (op_i == OP_SW);
                    if (timeout) begin
                        next_state = S_TRAP;
                    end else if (mem_ack_i) begin
                        next_state = (op_i == OP_LW) ? S_WB : S_IF;
                    end
                end
                S_WB: begin
                    reg_write_o = 1'b1;
                    if (op_i == OP_R) begin
                        reg_dst_o = 2'd1;
                    end else if (op_i == OP_LW) begin
                        mem_to_reg_o = 2'd1;
                    end
                    next_state = S_IF;
                end
                S_TRAP:  next_state = S_TRAP;
                default: next_state = S_TRAP;
            endcase
        end
    end

    assign state_o = state;
    assign trap_o  = (state == S_TRAP);

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cyc_cnt_o <= '0;
            ins_cnt_o <= '0;
        end else begin
            if (state != S_TRAP) begin
                cyc_cnt_o <= cyc_cnt_o + CNT_W'(1);
            end
            if ((next_state == S_IF) && (state != S_IF)) begin
                ins_cnt_o <= ins_cnt_o + CNT_W'(1);
            end
        end
    end
`else
    // Performance counters compiled out; FSM is unaffected.
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs are queued with their
// stimulus, then popped and compared at the falling edge. Honours MC_PERF_CNT_EN if defined.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       se, shift, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic [2:0] state;
    logic       trap;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt, ins_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, iord, irw, pcw;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] rd, m2r;
        logic       trap;
        logic       sa;
        logic [1:0] sbs;
        logic [2:0] aop;
        logic       se, sh;
    } obs_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ack;
        logic        z;
        obs_t        e;
        logic [23:0] m;
    } item_t;

    item_t sbq[$];

    // Field masks: control only, IF (no se/shift), ID/ld-st EX (no shift), R EX (no se), branch EX, TRAP enables.
    localparam logic [23:0] M_CTRL = 24'hFFFF00;
    localparam logic [23:0] M_IF   = 24'hFFFFFC;
    localparam logic [23:0] M_ID   = 24'hFFFFFE;
    localparam logic [23:0] M_EXR  = 24'hFFFFFD;
    localparam logic [23:0] M_EXB  = 24'hFFFFFC;
    localparam logic [23:0] M_TRAP = 24'hFB2100;

    multicycle_ctrl #(.WAIT_MAX(16)) dut (
        .clk_i(clk), .rst_i(rst), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ack_i(mem_ack), .mem_req_o(mem_req), .mem_we_o(mem_we), .iord_o(iord),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
        .se_o(se), .shift_o(shift), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
        .mem_to_reg_o(mem_to_reg), .state_o(state), .trap_o(trap)
`ifdef MC_PERF_CNT_EN
        , .cyc_cnt_o(cyc_cnt), .ins_cnt_o(ins_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.req = mem_req; o.we = mem_we; o.iord = iord; o.irw = ir_write;
        o.pcw = pc_write; o.pcs = pc_src; o.rw = reg_write; o.rd = reg_dst; o.m2r = mem_to_reg;
        o.trap = trap; o.sa = alu_src_a; o.sbs = alu_src_b; o.aop = alu_op; o.se = se; o.sh = shift;
        return o;
    endfunction

    function automatic obs_t x_if(input logic ack);
        obs_t o = '0;
        o.req = 1'b1; o.irw = ack; o.pcw = ack; o.sbs = 2'd1;
        return o;
    endfunction

    function automatic obs_t x_id(input logic [1:0] jmode);
        obs_t o = '0;
        o.st = 3'd1; o.sbs = 2'd3; o.se = 1'b1;
        if (jmode != 2'd0) begin o.pcw = 1'b1; o.pcs = 2'd2; end
        if (jmode == 2'd2) begin o.rw = 1'b1; o.rd = 2'd2; o.m2r = 2'd2; end
        return o;
    endfunction

    function automatic obs_t x_ex(input logic [1:0] b, input logic [2:0] aop, input logic s,
                                  input logic sh, input logic pcw, input logic [1:0] pcs);
        obs_t o = '0;
        o.st = 3'd2; o.sa = 1'b1; o.sbs = b; o.aop = aop; o.se = s; o.sh = sh;
        o.pcw = pcw; o.pcs = pcs;
        return o;
    endfunction

    function automatic obs_t x_mem(input logic we);
        obs_t o = '0;
        o.st = 3'd3; o.req = 1'b1; o.we = we; o.iord = 1'b1;
        return o;
    endfunction

    function automatic obs_t x_wb(input logic [1:0] rd, input logic [1:0] m2r);
        obs_t o = '0;
        o.st = 3'd4; o.rw = 1'b1; o.rd = rd; o.m2r = m2r;
        return o;
    endfunction

    function automatic obs_t x_trap();
        obs_t o = '0;
        o.st = 3'd7; o.trap = 1'b1;
        return o;
    endfunction

    task automatic push(input logic [5:0] o, input logic [5:0] f, input logic a, input logic z,
                        input obs_t e, input logic [23:0] m);
        sbq.push_back('{o, f, a, z, e, m});
    endtask

    task automatic q_r(input logic [5:0] f, input logic stray_ack);
        push(6'h00, f, 1'b1, 1'b0, x_if(1'b1), M_IF);
        push(6'h00, f, stray_ack, 1'b0, x_id(2'd0), M_ID);
        if (f == 6'h08) begin
            push(6'h00, f, stray_ack, 1'b0, x_ex(2'd0, 3'b010, 1'b0, 1'b0, 1'b1, 2'd3), M_CTRL);
        end else begin
            push(6'h00, f, stray_ack, 1'b0, x_ex(2'd0, 3'b010, 1'b0, f == 6'h03, 1'b0, 2'd0), M_EXR);
            push(6'h00, f, stray_ack, 1'b0, x_wb(2'd1, 2'd0), M_CTRL);
        end
    endtask

    task automatic q_i(input logic [5:0] o, input logic [2:0] aop, input logic s);
        push(o, 6'h00, 1'b1, 1'b0, x_if(1'b1), M_IF);
        push(o, 6'h00, 1'b0, 1'b0, x_id(2'd0), M_ID);
        push(o, 6'h00, 1'b0, 1'b0, x_ex(2'd2, aop, s, 1'b0, 1'b0, 2'd0), M_ID);
        push(o, 6'h00, 1'b0, 1'b0, x_wb(2'd0, 2'd0), M_CTRL);
    endtask

    task automatic q_mem(input logic [5:0] o, input int waits);
        push(o, 6'h00, 1'b1, 1'b0, x_if(1'b1), M_IF);
        push(o, 6'h00, 1'b0, 1'b0, x_id(2'd0), M_ID);
        push(o, 6'h00, 1'b0, 1'b0, x_ex(2'd2, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0), M_ID);
        for (int i = 0; i < waits; i++) push(o, 6'h00, 1'b0, 1'b0, x_mem(o == 6'h2B), M_CTRL);
        push(o, 6'h00, 1'b1, 1'b0, x_mem(o == 6'h2B), M_CTRL);
        if (o == 6'h23) push(o, 6'h00, 1'b0, 1'b0, x_wb(2'd0, 2'd1), M_CTRL);
    endtask

    task automatic q_br(input logic [5:0] o, input logic z, input logic taken);
        push(o, 6'h00, 1'b1, z, x_if(1'b1), M_IF);
        push(o, 6'h00, 1'b0, z, x_id(2'd0), M_ID);
        push(o, 6'h00, 1'b0, z, x_ex(2'd0, (o == 6'h04) ? 3'b001 : 3'b101, 1'b0, 1'b0, taken, 2'd1), M_EXB);
    endtask

    task automatic q_j(input logic link);
        push(link ? 6'h03 : 6'h02, 6'h00, 1'b1, 1'b0, x_if(1'b1), M_IF);
        push(link ? 6'h03 : 6'h02, 6'h00, 1'b0, 1'b0, x_id(link ? 2'd2 : 2'd1), M_ID);
    endtask

    // Leaves the bench 1 time unit after a rising edge with the DUT in IF.
    task automatic do_reset();
        rst = 1'b0; mem_ack = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b0; mem_ack = 1'b1; zero = 1'b1; op = 6'h23;
        @(negedge clk);
        got = sample();
        n_cmp++;
        if (got !== obs_t'(24'h0)) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h required=%h", got, 24'h0);
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_r_type();
        item_t it; obs_t got; int k = 0;
        do_reset();
        q_r(6'h20, 1'b1);
        q_r(6'h03, 1'b0);
        q_r(6'h08, 1'b0);
        q_j(1'b0);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            op = it.op; funct = it.fn; mem_ack = it.ack; zero = it.z;
            @(negedge clk);
            got = sample();
            n_cmp++;
            if ((got & it.m) !== (it.e & it.m)) begin
                n_bad++;
                $display("FAIL r_type step%0d got=%h required=%h mask=%h", k, got, it.e, it.m);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_i_type();
        item_t it; obs_t got; int k = 0;
        do_reset();
        q_i(6'h08, 3'b000, 1'b1);
        q_i(6'h0B, 3'b110, 1'b0);
        q_i(6'h0F, 3'b011, 1'b1);
        q_i(6'h0D, 3'b100, 1'b0);
        q_mem(6'h2B, 0);
        q_j(1'b0);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            op = it.op; funct = it.fn; mem_ack = it.ack; zero = it.z;
            @(negedge clk);
            got = sample();
            n_cmp++;
            if ((got & it.m) !== (it.e & it.m)) begin
                n_bad++;
                $display("FAIL i_type step%0d got=%h required=%h mask=%h", k, got, it.e, it.m);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        item_t it; obs_t got; int k = 0;
        do_reset();
        q_mem(6'h23, 3);
        q_mem(6'h23, 0);
        q_j(1'b0);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            op = it.op; funct = it.fn; mem_ack = it.ack; zero = it.z;
            @(negedge clk);
            got = sample();
            n_cmp++;
            if ((got & it.m) !== (it.e & it.m)) begin
                n_bad++;
                $display("FAIL lw_wait step%0d got=%h required=%h mask=%h", k, got, it.e, it.m);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        item_t it; obs_t got; int k = 0;
        do_reset();
        q_br(6'h04, 1'b1, 1'b1);
        q_br(6'h05, 1'b1, 1'b0);
        q_br(6'h04, 1'b0, 1'b0);
        q_br(6'h05, 1'b0, 1'b1);
        q_j(1'b0);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            op = it.op; funct = it.fn; mem_ack = it.ack; zero = it.z;
            @(negedge clk);
            got = sample();
            n_cmp++;
            if ((got & it.m) !== (it.e & it.m)) begin
                n_bad++;
                $display("FAIL branch step%0d got=%h required=%h mask=%h", k, got, it.e, it.m);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        item_t it; obs_t got; int k = 0;
        do_reset();
        q_j(1'b1);
        q_j(1'b0);
        q_j(1'b1);
        push(6'h02, 6'h00, 1'b1, 1'b0, x_if(1'b1), M_IF);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            op = it.op; funct = it.fn; mem_ack = it.ack; zero = it.z;
            @(negedge clk);
            got = sample();
            n_cmp++;
            if ((got & it.m) !== (it.e & it.m)) begin
                n_bad++;
                $display("FAIL jump step%0d got=%h required=%h mask=%h", k, got, it.e, it.m);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        item_t it; obs_t got; int k = 0;
        do_reset();
        q_r(6'h20, 1'b0);
        q_mem(6'h2B, 0);
        q_br(6'h04, 1'b1, 1'b1);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            op = it.op; funct = it.fn; mem_ack = it.ack; zero = it.z;
            @(negedge clk);
            got = sample();
            n_cmp++;
            if ((got & it.m) !== (it.e & it.m)) begin
                n_bad++;
                $display("FAIL back_to_back step%0d got=%h required=%h mask=%h", k, got, it.e, it.m);
            end
            k++;
            @(posedge clk); #1;
        end
`ifdef MC_PERF_CNT_EN
        n_cmp++;
        if (ins_cnt !== 32'd3) begin
            n_bad++;
            $display("FAIL ins_cnt got=%0d required=3", ins_cnt);
        end
        n_cmp++;
        if (cyc_cnt !== 32'd11) begin
            n_bad++;
            $display("FAIL cyc_cnt got=%0d required=11", cyc_cnt);
        end
`endif
    endtask

    task automatic test_timeout();
        item_t it; obs_t got; int k = 0;
        do_reset();
        for (int i = 0; i < 16; i++) push(6'h00, 6'h20, 1'b0, 1'b0, x_if(1'b0), M_IF);
        push(6'h00, 6'h20, 1'b1, 1'b0, x_trap(), M_TRAP);
        push(6'h00, 6'h20, 1'b1, 1'b0, x_trap(), M_TRAP);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            op = it.op; funct = it.fn; mem_ack = it.ack; zero = it.z;
            @(negedge clk);
            got = sample();
            n_cmp++;
            if ((got & it.m) !== (it.e & it.m)) begin
                n_bad++;
                $display("FAIL timeout step%0d got=%h required=%h mask=%h", k, got, it.e, it.m);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        item_t it; obs_t got; int k = 0;
        do_reset();
        push(6'h3F, 6'h00, 1'b1, 1'b0, x_if(1'b1), M_IF);
        push(6'h3F, 6'h00, 1'b0, 1'b0, x_id(2'd0), M_ID);
        push(6'h3F, 6'h00, 1'b1, 1'b0, x_trap(), M_TRAP);
        push(6'h00, 6'h20, 1'b1, 1'b0, x_trap(), M_TRAP);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            op = it.op; funct = it.fn; mem_ack = it.ack; zero = it.z;
            @(negedge clk);
            got = sample();
            n_cmp++;
            if ((got & it.m) !== (it.e & it.m)) begin
                n_bad++;
                $display("FAIL illegal step%0d got=%h required=%h mask=%h", k, got, it.e, it.m);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_mem();
        item_t it; obs_t got; obs_t exp_if; int k = 0;
        do_reset();
        push(6'h23, 6'h00, 1'b1, 1'b0, x_if(1'b1), M_IF);
        push(6'h23, 6'h00, 1'b0, 1'b0, x_id(2'd0), M_ID);
        push(6'h23, 6'h00, 1'b0, 1'b0, x_ex(2'd2, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0), M_ID);
        push(6'h23, 6'h00, 1'b0, 1'b0, x_mem(1'b0), M_CTRL);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            op = it.op; funct = it.fn; mem_ack = it.ack; zero = it.z;
            @(negedge clk);
            got = sample();
            n_cmp++;
            if ((got & it.m) !== (it.e & it.m)) begin
                n_bad++;
                $display("FAIL mid_mem step%0d got=%h required=%h mask=%h", k, got, it.e, it.m);
            end
            k++;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        got = sample();
        n_cmp++;
        if (got !== obs_t'(24'h0)) begin
            n_bad++;
            $display("FAIL mid_mem_reset got=%h required=%h", got, 24'h0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        got = sample();
        exp_if = x_if(1'b0);
        n_cmp++;
        if ((got & M_IF) !== (exp_if & M_IF)) begin
            n_bad++;
            $display("FAIL mid_mem_release got=%h required=%h", got, exp_if);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_lw_wait();
        test_branch();
        test_jump();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
